// File: rtl/dma_fifo_peripheral.sv
// dma_fifo_peripheral
//   Byte-stream peripheral feeding the DMA controller in I/O-to-memory mode.
//   A local source pushes bytes into an internal FIFO. Once the fill level
//   reaches THRESH, DREQ is raised. During DMA I/O-read cycles (DACK with
//   CB==CB_IOR) the FIFO head is driven onto DB and popped at the end of the
//   cycle.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   ENABLE     device enable; 0 freezes the FIFO and releases the bus
//   src_data   byte from the local source
//   src_valid  src_data valid this cycle
//   src_ready  FIFO can accept a byte this cycle
//   DB         system data bus (tri-state)
//   CB         system control bus
//   DACK       DMA acknowledge for this channel
//   DREQ       DMA request for this channel (registered, with hysteresis)
//   level      FIFO occupancy
//   overflow   sticky: push attempted while full
//   underflow  sticky: bus read attempted while empty
module dma_fifo_peripheral #(
  parameter int         DEPTH  = 8,
  parameter int         THRESH = 4,
  parameter logic [3:0] CB_IOR = 4'b0100
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic [7:0]               src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  inout  wire  [7:0]               DB,
  input  logic [3:0]               CB,
  input  logic                     DACK,
  output logic                     DREQ,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} dreq_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic          full;
  logic          empty;
  logic          rd_cyc;
  logic          push;
  logic          pop;
  logic          drive_en;
  logic [7:0]    db_out;
  dreq_state_t   state;
  dreq_state_t   state_next;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign src_ready = ENABLE && !full;
  assign rd_cyc    = ENABLE && DACK && (CB == CB_IOR);
  assign push      = src_valid && src_ready;
  assign pop       = rd_cyc && !empty;

  // An empty read still drives the bus, with zeros, so the DMA never
  // latches a floating value.
  assign db_out   = empty ? 8'h00 : mem[rd_ptr];
  // Gated by RST so the bus is released during reset, even with DACK active.
  assign drive_en = rd_cyc && !RST;
  assign DB       = drive_en ? db_out : 8'bz;

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + 1'b1;
    else if (pop && !push)
      level_next = level - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= src_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer rollover is modulo DEPTH.
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      if (src_valid && ENABLE && full)
        overflow <= 1'b1;
      if (rd_cyc && empty)
        underflow <= 1'b1;
    end
  end

  // DREQ state register
  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Demand-mode hysteresis: request at THRESH, hold until the FIFO is empty.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ENABLE && (level_next >= LW'(THRESH))) state_next = REQ;
      REQ:  if (!ENABLE || (level_next == '0))         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign DREQ = (state == REQ);

endmodule

// File: tb/tb_dma_fifo_peripheral.sv
// Directed bench for dma_fifo_peripheral (DEPTH=8, THRESH=4).
// DB carries a pull-up, so a released bus reads back as 8'hFF. Test data
// never places 8'hFF on the bus.
module tb_dma_fifo_peripheral;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ENABLE;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  wire  [7:0] DB;
  logic [3:0] CB;
  logic       DACK;
  logic       DREQ;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] IOR = 4'b0100;
  localparam logic [7:0] REL = 8'hFF;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (DB[i]);
  end

  dma_fifo_peripheral #(.DEPTH(8), .THRESH(4), .CB_IOR(IOR)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .DB(DB), .CB(CB), .DACK(DACK), .DREQ(DREQ),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    src_data  = b;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b1; src_data = 8'h00; src_valid = 1'b0;
    CB = 4'h0; DACK = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_dreq", DREQ, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_ready", src_ready, 1);
    chk("rst_db", DB, REL);

    // 1: fill to threshold
    push(8'hA1); push(8'hA2); push(8'hA3);
    chk("t1_level3", level, 3);
    chk("t1_dreq_lo", DREQ, 0);
    chk("t1_db_rel", DB, REL);
    push(8'hA4);
    chk("t1_level4", level, 4);
    chk("t1_dreq_hi", DREQ, 1);

    // 2: DMA burst drains four bytes; DREQ holds until empty
    DACK = 1'b1; CB = IOR;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_db", DB, 32'hA1 + i);
      tick();
      if (i == 3) DACK = 1'b0;
      chk("t2_level", level, 3 - i);
      chk("t2_dreq", DREQ, (i < 3) ? 1 : 0);
    end

    // 3: fill to full, overflow attempt, drain
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("t3_level8", level, 8);
    src_data = 8'hFF; src_valid = 1'b1;
    #1;
    chk("t3_ready_full", src_ready, 0);
    tick();
    src_valid = 1'b0;
    chk("t3_ovf", overflow, 1);
    chk("t3_level_full", level, 8);
    DACK = 1'b1; CB = IOR;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_drain_db", DB, 32'h10 + i);
      tick();
    end
    DACK = 1'b0;
    chk("t3_level0", level, 0);
    chk("t3_dreq0", DREQ, 0);

    // 4: concurrent push/pop at level 5, then drain across the wrap point
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    chk("t4_level5", level, 5);
    DACK = 1'b1; CB = IOR;
    for (int i = 0; i < 3; i++) begin
      src_data = 8'h30 + 8'(i); src_valid = 1'b1;
      #1;
      chk("t4_conc_db", DB, 32'h20 + i);
      tick();
      chk("t4_conc_level", level, 5);
    end
    src_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_wrap_db", DB, (i < 2) ? 32'h23 + i : 32'h30 + i - 2);
      tick();
    end
    DACK = 1'b0;
    chk("t4_level0", level, 0);
    chk("t4_dreq0", DREQ, 0);

    // 5: non-IOR DACK is ignored; empty IOR read returns 00 and flags
    push(8'h40);
    DACK = 1'b1; CB = 4'b0001;
    #1;
    chk("t5_nonior_db", DB, REL);
    tick();
    chk("t5_nonior_level", level, 1);
    chk("t5_nonior_unf", underflow, 0);
    CB = IOR;
    #1;
    chk("t5_last_db", DB, 32'h40);
    tick();
    chk("t5_last_level", level, 0);
    chk("t5_last_unf", underflow, 0);
    #1;
    chk("t5_empty_db", DB, 32'h00);
    tick();
    DACK = 1'b0;
    chk("t5_empty_unf", underflow, 1);
    chk("t5_empty_level", level, 0);

    // 6a: reset mid-burst
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    chk("t6_level6", level, 6);
    chk("t6_dreq1", DREQ, 1);
    DACK = 1'b1; CB = IOR;
    #1;
    chk("t6_burst_db", DB, 32'h50);
    tick();
    chk("t6_burst_level", level, 5);
    RST = 1'b1;
    #1;
    chk("t6_rst_db", DB, REL);
    tick();
    RST = 1'b0; DACK = 1'b0;
    #1;
    chk("t6_rst_level", level, 0);
    chk("t6_rst_dreq", DREQ, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_unf", underflow, 0);
    chk("t6_rst_dbrel", DB, REL);

    // 6b: ENABLE=0 drops DREQ, freezes FIFO, releases bus
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    chk("t6_en_dreq1", DREQ, 1);
    ENABLE = 1'b0; DACK = 1'b1; CB = IOR;
    #1;
    chk("t6_dis_ready", src_ready, 0);
    chk("t6_dis_db", DB, REL);
    tick();
    DACK = 1'b0;
    chk("t6_dis_dreq", DREQ, 0);
    chk("t6_dis_level", level, 6);
    ENABLE = 1'b1;
    tick();
    chk("t6_reen_dreq", DREQ, 1);
    chk("t6_reen_level", level, 6);
    DACK = 1'b1;
    #1;
    chk("t6_reen_db", DB, 32'h60);
    DACK = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
